// File: rtl/tetris_grid_render.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tetris_grid_render
//
// Reader side of the playfield grid. Scans a VGA raster, maps each pixel that
// falls inside the grid window to a 16x16 cell of the 22x10 colour grid, and
// produces RGB444 with aligned sync and data-enable. The grid is copied into a
// shadow register once per frame, at the first pixel of vertical blanking, so
// a frame is always drawn from one consistent snapshot.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (independent of pix_en)
//   pix_en      pixel strobe; all state advances only when high
//   grid        playfield, [row][col][code], row 0 top, col 0 left
//   hsync       horizontal sync, active low
//   vsync       vertical sync, active low
//   de          display enable, high in the active area
//   red/green/blue  4-bit colour components
//   frame_tick  one-clk pulse on the cycle the snapshot is taken
//
// Pipeline: counters (stage 0) -> cell lookup (stage 1) -> colour (stage 2).
// A counter value reaches the pins two pix_en ticks later.
// -----------------------------------------------------------------------------
module tetris_grid_render #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CELL_LOG2 = 4,
    parameter int X_ORG     = 240,
    parameter int Y_ORG     = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    input  logic [21:0][9:0][2:0] grid,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  frame_tick
);

    localparam int HT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int GRID_W = 10 << CELL_LOG2;
    localparam int GRID_H = 22 << CELL_LOG2;
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_LOG2) - 1);

    typedef logic [21:0][9:0][2:0] grid_t;

    function automatic logic [11:0] palette(input logic [2:0] code);
        case (code)
            3'd0:    palette = 12'h000;
            3'd1:    palette = 12'h0FF;
            3'd2:    palette = 12'hFF0;
            3'd3:    palette = 12'hA0F;
            3'd4:    palette = 12'h0F0;
            3'd5:    palette = 12'hF00;
            3'd6:    palette = 12'h00F;
            default: palette = 12'hF80;
        endcase
    endfunction

    // Stage 0: raster counters and the shadow grid.
    logic [9:0] h_q, h_d, v_q, v_d;
    grid_t      shadow_q;

    // Stage 0 decode.
    logic       snap, de_raw, hs_raw, vs_raw, in_grid, cell_edge;
    logic [9:0] h_off, v_off;
    logic [3:0] col;
    logic [4:0] row;
    logic [2:0] code;

    // Stage 1. Sync flags are kept active-high inside so every pipeline
    // register clears to 0 and the pins still idle high during reset.
    logic [2:0] code_q;
    logic       in_grid_q, edge_q, de1_q, hs1_q, vs1_q;

    // Stage 2.
    logic [11:0] rgb_q, rgb_d;
    logic        de2_q, hs2_q, vs2_q;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == 10'(HT - 1)) begin
            h_d = '0;
            v_d = (v_q == 10'(VT - 1)) ? '0 : v_q + 10'd1;
        end
    end

    assign snap       = pix_en && (h_q == '0) && (v_q == 10'(V_ACTIVE));
    assign frame_tick = snap && !rst;

    assign de_raw = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    assign hs_raw = (h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw = (v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC));

    assign in_grid = (h_q >= 10'(X_ORG)) && (h_q < 10'(X_ORG + GRID_W)) &&
                     (v_q >= 10'(Y_ORG)) && (v_q < 10'(Y_ORG + GRID_H));

    // Offsets are forced to 0 outside the window so the lookup index never
    // comes from an underflowed subtraction.
    assign h_off = in_grid ? h_q - 10'(X_ORG) : '0;
    assign v_off = in_grid ? v_q - 10'(Y_ORG) : '0;
    assign col   = 4'(h_off >> CELL_LOG2);
    assign row   = 5'(v_off >> CELL_LOG2);
    assign code  = shadow_q[row][col];

    // Last pixel column or last line of a cell.
    assign cell_edge = in_grid && (((h_off & CELL_MASK) == CELL_MASK) ||
                                   ((v_off & CELL_MASK) == CELL_MASK));

    always_comb begin
        rgb_d = 12'h000;
        if (de1_q) begin
            if (!in_grid_q)
                rgb_d = 12'h111;
            else if ((code_q == 3'd0) && edge_q)
                rgb_d = 12'h333;
            else
                rgb_d = palette(code_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q       <= '0;
            v_q       <= '0;
            // NOTE: the shadow grid is reset as well: after reset the first
            // frame must render as an empty playfield, not stale contents.
            shadow_q  <= '0;
            code_q    <= '0;
            in_grid_q <= 1'b0;
            edge_q    <= 1'b0;
            de1_q     <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            rgb_q     <= '0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
        end else if (pix_en) begin
            h_q       <= h_d;
            v_q       <= v_d;
            // Stage 1 below reads shadow_q, so on the snapshot tick it still
            // sees the previous frame's copy.
            if (snap)
                shadow_q <= grid;
            code_q    <= code;
            in_grid_q <= in_grid;
            edge_q    <= cell_edge;
            de1_q     <= de_raw;
            hs1_q     <= hs_raw;
            vs1_q     <= vs_raw;
            rgb_q     <= rgb_d;
            de2_q     <= de1_q;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
        end
    end

    assign hsync = ~hs2_q;
    assign vsync = ~vs2_q;
    assign de    = de2_q;
    assign red   = rgb_q[11:8];
    assign green = rgb_q[7:4];
    assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_tetris_grid_render.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_tetris_grid_render
//
// Two instances share clk/rst/pix_en/grid:
//   dut_s  scaled raster (48x66 total, 40x60 active, 2 px cells, grid window
//          x 10..29, y 8..51) so several whole frames fit in a short run
//   dut_f  default 800x525 raster, used for reset values and line timing
//
// Stimulus pushes hand-computed pixel expectations (due tick, de/hsync/vsync,
// RGB) into a scoreboard queue; an independent monitor counts pix_en ticks and
// pops/compares whenever the DUT presents the pixel that is due.
// -----------------------------------------------------------------------------
module tb_tetris_grid_render;

    localparam int S_HT   = 48;
    localparam int S_FT   = 48 * 66;   // ticks per scaled frame
    localparam int S_SNAP = 60 * 48;   // h=0, v=V_ACTIVE
    localparam int F_FT   = 800 * 525;
    localparam int F_SNAP = 480 * 800;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pix_en;
    logic [21:0][9:0][2:0] grid;

    logic       hsync_s, vsync_s, de_s, ft_s;
    logic [3:0] red_s, green_s, blue_s;
    logic       hsync_f, vsync_f, de_f, ft_f;
    logic [3:0] red_f, green_f, blue_f;

    always #5 clk = ~clk;

    tetris_grid_render #(
        .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(60), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CELL_LOG2(1), .X_ORG(10), .Y_ORG(8)
    ) dut_s (
        .clk(clk), .rst(rst), .pix_en(pix_en), .grid(grid),
        .hsync(hsync_s), .vsync(vsync_s), .de(de_s),
        .red(red_s), .green(green_s), .blue(blue_s), .frame_tick(ft_s)
    );

    tetris_grid_render dut_f (
        .clk(clk), .rst(rst), .pix_en(pix_en), .grid(grid),
        .hsync(hsync_f), .vsync(vsync_f), .de(de_f),
        .red(red_f), .green(green_f), .blue(blue_f), .frame_tick(ft_f)
    );

    typedef struct {
        int unsigned due;
        int          f;
        int          x;
        int          y;
        logic [14:0] exp;   // {de, hsync, vsync, rgb}
    } sb_t;

    sb_t sb[$];

    int checks   = 0;
    int failures = 0;

    int unsigned e_mon = 0;   // pix_en ticks since reset release
    bit new_tick   = 1'b0;
    bit prev_stall = 1'b0;
    bit seg_a      = 1'b0;
    int ft_err = 0, ft_cnt = 0, hold_err = 0;
    int hs_low = 0, hs_first = -1, de_hi = 0, de_first = -1, vs_low = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(int f, int x, int y, logic de_e, logic hs_e, logic vs_e,
                        logic [11:0] rgb_e);
        sb_t e;
        e.due = f * S_FT + y * S_HT + x + 2;
        e.f   = f;
        e.x   = x;
        e.y   = y;
        e.exp = {de_e, hs_e, vs_e, rgb_e};
        sb.push_back(e);
    endtask

    task automatic px(int f, int x, int y, logic [11:0] rgb_e);
        push(f, x, y, 1'b1, 1'b1, 1'b1, rgb_e);
    endtask

    task automatic blank(int f, int x, int y, logic hs_e, logic vs_e);
        push(f, x, y, 1'b0, hs_e, vs_e, 12'h000);
    endtask

    // Advance until target ticks have elapsed; stall=1 gives pix_en 1-of-4.
    task automatic run_to(int unsigned target, bit stall);
        int unsigned cyc   = 0;
        int unsigned limit = 4 * (target - e_mon) + 16;
        while (e_mon < target) begin
            if (cyc > limit) begin
                checks++;
                failures++;
                $display("FAIL run_to timeout: tick %0d target %0d", e_mon, target);
                return;
            end
            pix_en = stall ? (cyc % 4 == 0) : 1'b1;
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: tick counting on posedge, sampling and comparing on negedge.
    initial begin
        sb_t         e;
        logic [14:0] s_out;
        logic [14:0] last_out = '0;
        bit          exp_ft;
        forever begin
            @(posedge clk);
            if (rst)
                e_mon = 0;
            else if (pix_en)
                e_mon++;
            new_tick   = !rst && pix_en;
            prev_stall = !rst && !pix_en;

            @(negedge clk);
            s_out = {de_s, hsync_s, vsync_s, red_s, green_s, blue_s};

            while (sb.size() > 0 && sb[0].due <= e_mon) begin
                e = sb.pop_front();
                if (e.due == e_mon) begin
                    check($sformatf("pixel f%0d (%0d,%0d) {de,hs,vs,rgb}", e.f, e.x, e.y),
                          32'(s_out), 32'(e.exp));
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL pixel f%0d (%0d,%0d) missed: due %0d now %0d",
                             e.f, e.x, e.y, e.due, e_mon);
                end
            end

            exp_ft = !rst && pix_en && (e_mon % S_FT == S_SNAP);
            if (ft_s !== exp_ft) begin
                ft_err++;
                $display("FAIL frame_tick small at tick %0d: got %0b expected %0b",
                         e_mon, ft_s, exp_ft);
            end
            exp_ft = !rst && pix_en && (e_mon % F_FT == F_SNAP);
            if (ft_f !== exp_ft) ft_err++;
            if (ft_s) ft_cnt++;

            if (prev_stall && s_out !== last_out) hold_err++;
            last_out = s_out;

            if (new_tick && seg_a) begin
                if (e_mon >= 2 && e_mon < 802) begin
                    if (!hsync_f) begin
                        hs_low++;
                        if (hs_first < 0) hs_first = int'(e_mon);
                    end
                    if (de_f) begin
                        de_hi++;
                        if (de_first < 0) de_first = int'(e_mon);
                    end
                end
                if (e_mon >= S_FT + 2 && e_mon < 2 * S_FT + 2 && !vsync_s)
                    vs_low++;
            end
        end
    end

    // Stimulus.
    initial begin
        rst    = 1'b1;
        pix_en = 1'b1;
        grid   = '0;
        grid[0][0] = 3'd5;
        for (int c = 0; c < 10; c++) grid[21][c] = 3'd7;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset hsync", 32'(hsync_s), 32'd1);
        check("reset vsync", 32'(vsync_s), 32'd1);
        check("reset de", 32'(de_s), 32'd0);
        check("reset rgb", 32'({red_s, green_s, blue_s}), 32'h000);
        check("reset frame_tick", 32'(ft_s), 32'd0);
        check("reset full syncs/de", 32'({hsync_f, vsync_f, de_f, ft_f}), 32'b1100);
        check("reset full rgb", 32'({red_f, green_f, blue_f}), 32'h000);
        rst   = 1'b0;
        seg_a = 1'b1;

        // Frame 0: shadow still all CL0.
        px(0, 5, 5, 12'h111);
        blank(0, 42, 5, 1'b0, 1'b1);
        px(0, 10, 8, 12'h000);
        px(0, 11, 8, 12'h333);
        px(0, 20, 18, 12'h000);
        px(0, 10, 50, 12'h000);
        blank(0, 0, 62, 1'b1, 1'b0);
        // Frame 1: first snapshot (grid[0][0]=CL5, floor CL7).
        px(1, 9, 8, 12'h111);
        px(1, 10, 8, 12'hF00);
        px(1, 11, 8, 12'hF00);
        px(1, 30, 8, 12'h111);
        px(1, 12, 9, 12'h333);
        px(1, 20, 18, 12'h000);
        px(1, 5, 20, 12'h111);
        px(1, 10, 50, 12'hF80);
        px(1, 29, 51, 12'hF80);
        px(1, 10, 52, 12'h111);
        px(1, 39, 59, 12'h111);
        blank(1, 40, 59, 1'b1, 1'b1);
        blank(1, 0, 60, 1'b1, 1'b1);
        // Frame 2 (stalled): grid[5][5]=CL1 now in the shadow.
        px(2, 10, 8, 12'hF00);
        px(2, 20, 18, 12'h0FF);
        px(2, 21, 19, 12'h0FF);

        run_to(S_FT + 10 * S_HT, 1'b0);
        grid[5][5] = 3'd1;              // not visible until the next snapshot
        run_to(2 * S_FT, 1'b0);
        run_to(3 * S_FT, 1'b1);
        run_to(3 * S_FT + 30 * S_HT, 1'b0);
        check("scoreboard drained before mid-frame reset", sb.size(), 0);

        seg_a = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // After reset: empty shadow until the first new snapshot.
        px(0, 10, 8, 12'h000);
        px(0, 11, 8, 12'h333);
        px(0, 20, 18, 12'h000);
        px(0, 10, 50, 12'h000);
        px(1, 10, 8, 12'hF00);
        px(1, 20, 18, 12'h0FF);
        px(1, 10, 50, 12'hF80);

        run_to(2 * S_FT, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        check("scoreboard drained", sb.size(), 0);
        check("frame_tick per-cycle errors", ft_err, 0);
        check("frame_tick pulse count", ft_cnt, 5);
        check("output hold errors during stall", hold_err, 0);
        check("full hsync first low tick", hs_first, 658);
        check("full hsync low ticks per line", hs_low, 96);
        check("full de first high tick", de_first, 2);
        check("full de high ticks per line", de_hi, 640);
        check("small vsync low ticks per frame", vs_low, 2 * S_HT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
